fcb_csr_arb: RTL and testbench

FCB_CSR_ARB -- requirements
Module: fcb_csr_arb

---
 rtl/fcb_csr_arb.sv | 154 +++++++++++++++
 tb/tb_fcb_csr_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcb_csr_arb.sv
// Two-requester round-robin arbiter onto an APB-style CSR bus; done pulse 3 cycles after grant at best, requests wait while busy.
// Optional ACCESS watchdog is built only when FCB_CSR_ARB_TIMEOUT_EN is defined (limit set by TIMEOUT_CYCLES).
module fcb_csr_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        FCB_CLK,
    input  logic        FCB_RST_N,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_done,
    output logic        req1_err,
    output logic [31:0] rd_data,
    output logic        csr_psel,
    output logic        csr_penable,
    output logic        csr_pwrite,
    output logic [31:0] csr_paddr,
    output logic [31:0] csr_pwdata,
    input  logic        csr_pready,
    input  logic        csr_pslverr,
    input  logic [31:0] csr_prdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_gnt;
    logic        r_gnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_any_req;
    logic        w_gnt;
    logic        w_tmo;

`ifdef FCB_CSR_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Counts completed ACCESS cycles; the last allowed cycle is TIMEOUT_CYCLES.
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge FCB_CLK or negedge FCB_RST_N) begin
        if (!FCB_RST_N) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == S_SETUP) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == S_ACCESS) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo = (r_state == S_ACCESS) && (r_tmo_cnt == TMO_LAST);
`else
    logic w_unused_tmo_cfg;
    assign w_unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign w_tmo            = 1'b0;
`endif

    always_comb begin
        w_any_req = req0_valid | req1_valid;
        w_gnt     = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt = ~r_last_gnt;
        end else if (req1_valid) begin
            w_gnt = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (csr_pready || w_tmo) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge FCB_CLK or negedge FCB_RST_N) begin
        if (!FCB_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge FCB_CLK or negedge FCB_RST_N) begin
        if (!FCB_RST_N) begin
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt      <= w_gnt;
                        r_last_gnt <= w_gnt;
                        r_write    <= w_gnt ? req1_write : req0_write;
                        r_addr     <= w_gnt ? req1_addr  : req0_addr;
                        r_wdata    <= w_gnt ? req1_wdata : req0_wdata;
                    end
                end
                S_ACCESS: begin
                    // A real completion wins over a timeout on the same cycle.
                    if (csr_pready) begin
                        r_err <= csr_pslverr;
                        if (!r_write) begin
                            r_rdata <= csr_prdata;
                        end
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign csr_psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign csr_penable = (r_state == S_ACCESS);
    assign csr_pwrite  = r_write;
    assign csr_paddr   = r_addr;
    assign csr_pwdata  = r_wdata;
    assign busy        = (r_state != S_IDLE);
    assign req0_done   = (r_state == S_DONE) && !r_gnt;
    assign req1_done   = (r_state == S_DONE) &&  r_gnt;
    assign req0_err    = req0_done && r_err;
    assign req1_err    = req1_done && r_err;
    assign rd_data     = r_rdata;

endmodule

// File: tb/tb_fcb_csr_arb.sv
// Bench for fcb_csr_arb: directed vector table, hand sequences and a randomized transaction-level scoreboard.
module tb_fcb_csr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  v;
    logic [1:0]  wr;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        pready, pslverr;
    logic [31:0] prdata;
    wire  [1:0]  dn, er;
    wire  [31:0] rd_data, paddr, pwdata;
    wire         psel, penable, pwrite, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fcb_csr_arb #(.TIMEOUT_CYCLES(4)) dut (
        .FCB_CLK(clk), .FCB_RST_N(rst_n),
        .req0_valid(v[0]), .req0_write(wr[0]), .req0_addr(ad[0]), .req0_wdata(wd[0]),
        .req0_done(dn[0]), .req0_err(er[0]),
        .req1_valid(v[1]), .req1_write(wr[1]), .req1_addr(ad[1]), .req1_wdata(wd[1]),
        .req1_done(dn[1]), .req1_err(er[1]),
        .rd_data(rd_data),
        .csr_psel(psel), .csr_penable(penable), .csr_pwrite(pwrite),
        .csr_paddr(paddr), .csr_pwdata(pwdata),
        .csr_pready(pready), .csr_pslverr(pslverr), .csr_prdata(prdata),
        .busy(busy)
    );

    typedef struct {
        int          r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          waits;
        logic [31:0] prd;
        logic        slv;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v = 2'b00;
        pready = 1'b0;
        pslverr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_xfer(input vec_t t);
        int o;
        o = 1 - t.r;
        v[t.r] = 1'b1; wr[t.r] = t.w; ad[t.r] = t.a; wd[t.r] = t.d;
        pready = 1'b0;
        tick();
        check("setup_psel", {psel, penable}, 2'b10);
        check("setup_paddr", paddr, t.a);
        check("setup_pwdata", pwdata, t.d);
        check("setup_pwrite", pwrite, t.w);
        check("setup_busy", busy, 1'b1);
        tick();
        check("access_psel", {psel, penable}, 2'b11);
        for (int k = 0; k < t.waits; k++) begin
            pready = 1'b0;
            tick();
            check("stall_penable", penable, 1'b1);
            check("stall_nodone", dn, 2'b00);
        end
        pready = 1'b1; prdata = t.prd; pslverr = t.slv;
        tick();
        check("done_req", dn[t.r], 1'b1);
        check("done_other", dn[o], 1'b0);
        check("done_err", er[t.r], t.exp_err);
        check("done_rd", rd_data, t.exp_rd);
        check("done_psel", {psel, penable}, 2'b00);
        v[t.r] = 1'b0; pready = 1'b0; pslverr = 1'b0;
        tick();
        check("after_done", dn, 2'b00);
        check("after_busy", busy, 1'b0);
        check("after_rd_hold", rd_data, t.exp_rd);
    endtask

    initial begin
        int got_who [4];
        int got_cyc [4];
        int n_got;
        int g, win, last, stall, n_done;
        logic pend, pend_err, gw;
        logic [31:0] ga, gd, exp_rd;
        logic [1:0] pv;
        logic pb;
        vec_t t;

        tbl[0] = '{0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 0, 32'h0,         1'b0, 1'b0, 32'h0};
        tbl[1] = '{1, 1'b0, 32'h0000_0020, 32'h0,         5, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678};
        tbl[2] = '{0, 1'b0, 32'h0000_0044, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[3] = '{1, 1'b1, 32'h0000_0080, 32'h55AA_55AA, 2, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[4] = '{0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[5] = '{1, 1'b0, 32'h0000_0000, 32'h0,         0, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0BAD_0BAD};

        rst_n = 1'b0; v = 2'b00; wr = 2'b00; ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
        v = 2'b11;
        repeat (2) tick();
        check("rst_bus", {psel, penable, pwrite, busy}, 4'b0000);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_done_err", {dn, er}, 4'b0000);
        check("rst_rd", rd_data, 32'h0);

        // Contention straight out of reset: requester 0 first, then alternating.
        do_reset();
        wr = 2'b11; ad[0] = 32'h200; ad[1] = 32'h204; wd[0] = 32'h1; wd[1] = 32'h2;
        pready = 1'b1; v = 2'b11; n_got = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("contend_onehot", dn[0] & dn[1], 1'b0);
            if (dn != 2'b00 && n_got < 4) begin
                got_who[n_got] = dn[1] ? 1 : 0;
                got_cyc[n_got] = c;
                n_got++;
            end
            if (c == 15) v = 2'b00;
        end
        check("contend_count", n_got, 4);
        for (int i = 0; i < 4; i++) begin
            check("contend_order", got_who[i], i % 2);
            check("contend_cycle", got_cyc[i], 3 + 4 * i);
        end
        tick();
        check("contend_idle", busy, 1'b0);
        pready = 1'b0;

        for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

        // Inputs change after grant; the latched transfer must be unaffected.
        v[1] = 1'b1; wr[1] = 1'b1; ad[1] = 32'h100; wd[1] = 32'h1111_1111;
        tick();
        check("mid_setup_addr", paddr, 32'h100);
        v[1] = 1'b0; wr[1] = 1'b0; ad[1] = 32'hBAD; wd[1] = 32'h0;
        tick();
        check("mid_access_addr", paddr, 32'h100);
        check("mid_access_data", pwdata, 32'h1111_1111);
        check("mid_access_wr", pwrite, 1'b1);
        pready = 1'b1; prdata = 32'h7777_7777; pslverr = 1'b0;
        tick();
        check("mid_done", dn, 2'b10);
        check("mid_rd_unchanged", rd_data, 32'h0BAD_0BAD);
        pready = 1'b0;
        tick();
        check("idle_hold_addr", paddr, 32'h100);
        check("idle_hold_data", pwdata, 32'h1111_1111);
        check("idle_hold_wr", pwrite, 1'b1);

        v[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h300; pready = 1'b0;
        tick();
        tick();
`ifdef FCB_CSR_ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check("tmo_wait", {penable, dn}, 3'b100);
        end
        tick();
        check("tmo_done", dn, 2'b01);
        check("tmo_err", er, 2'b01);
        check("tmo_rd", rd_data, 32'h0);
        v[0] = 1'b0; pready = 1'b1; prdata = 32'hFFFF_0000; pslverr = 1'b0;
        tick();
        check("tmo_late_ready", {busy, dn}, 3'b000);
        check("tmo_late_rd", rd_data, 32'h0);
        pready = 1'b0;
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            check("notmo_busy", {busy, penable, dn}, 4'b1100);
        end
        pready = 1'b1; prdata = 32'h5A5A_5A5A; pslverr = 1'b0;
        tick();
        check("notmo_done", dn, 2'b01);
        check("notmo_err", er, 2'b00);
        check("notmo_rd", rd_data, 32'h5A5A_5A5A);
        v[0] = 1'b0; pready = 1'b0;
        tick();
`endif

        // Reset in the middle of ACCESS drops the transfer with no done.
        v[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h400; wd[0] = 32'h4;
        tick();
        tick();
        check("rstmid_access", penable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_async_psel", {psel, penable, busy}, 3'b000);
        check("rstmid_nodone", dn, 2'b00);
        v[0] = 1'b0;
        tick();
        check("rstmid_hold", dn, 2'b00);
        rst_n = 1'b1;
        tick();
        check("rstmid_idle", {busy, dn}, 3'b000);
        t = '{1, 1'b0, 32'h0000_0500, 32'h0, 1, 32'h1357_2468, 1'b0, 1'b0, 32'h1357_2468};
        run_xfer(t);

        // Random traffic against a transaction-level scoreboard.
        do_reset();
        g = 0; last = 1; pend = 1'b0; pend_err = 1'b0; exp_rd = 32'h0; pv = 2'b00; pb = 1'b0;
        stall = 0; n_done = 0; gw = 1'b0; ga = 0; gd = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (pend) begin
                check("rnd_done", dn, (g == 1) ? 2'b10 : 2'b01);
                check("rnd_err", er, (g == 1) ? {pend_err, 1'b0} : {1'b0, pend_err});
                check("rnd_rd", rd_data, exp_rd);
                pend = 1'b0;
                n_done++;
            end else begin
                check("rnd_nodone", dn, 2'b00);
            end
            check("rnd_busy", busy, psel | (dn != 2'b00));
            if (!pb && pv != 2'b00) begin
                check("rnd_grant", {psel, penable}, 2'b10);
                win = (pv == 2'b11) ? (1 - last) : (pv[1] ? 1 : 0);
                last = win; g = win;
                gw = wr[win]; ga = ad[win]; gd = wd[win];
                check("rnd_setup_addr", paddr, ga);
                check("rnd_setup_data", pwdata, gd);
                check("rnd_setup_wr", pwrite, gw);
            end else begin
                check("rnd_spurious_setup", psel & ~penable, 1'b0);
            end
            if (psel && penable) begin
                check("rnd_access_addr", paddr, ga);
                check("rnd_access_wr", pwrite, gw);
                if (stall >= 2 || ($urandom % 2) == 0) begin
                    pready = 1'b1; prdata = $urandom; pslverr = 1'($urandom % 2);
                    pend = 1'b1; pend_err = pslverr;
                    if (!gw) exp_rd = prdata;
                    stall = 0;
                end else begin
                    pready = 1'b0;
                    stall++;
                end
            end else begin
                pready = 1'($urandom % 2); prdata = $urandom; pslverr = 1'($urandom % 2);
            end
            pb = busy;
            for (int r = 0; r < 2; r++) begin
                if (dn[r]) v[r] = 1'b0;
                if (!v[r] && ($urandom % 3) == 0) begin
                    v[r] = 1'b1; wr[r] = 1'($urandom % 2); ad[r] = $urandom; wd[r] = $urandom;
                end
            end
            pv = v;
        end
        check("rnd_activity", n_done > 300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
